add_4_seg_scan: RTL and testbench



---
 rtl/add_4_seg_scan.sv | 136 +++++++++++++
 tb/tb_add_4_seg_scan.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/add_4_seg_scan.sv
// rtl/add_4_seg_scan.sv - captures adder operands/result and scans them onto a 4-digit 7-segment display
// Optional build macro: LEADING_ZERO_BLANK_EN (darkens the tens digit when it is zero).
module add_4_seg_scan #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [3:0] in_0,
    input  logic [3:0] in_1,
    input  logic       cin,
    input  logic [3:0] sum,
    input  logic       cout,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PCNT_MAX = PW'(SCAN_DIV - 1);

    logic [3:0]    a_r;
    logic [3:0]    b_r;
    logic          c_r;
    logic [4:0]    res_r;
    logic [PW-1:0] pcnt;
    logic [1:0]    idx;
    logic          tick;

    logic [1:0] tens;
    logic [4:0] tens_off;
    logic [3:0] digit;
    logic [3:0] an_next;
    logic [6:0] seg_next;
    logic       dp_next;

    function automatic logic [6:0] font(input logic [3:0] d);
        case (d)
            4'h0: font = 7'h40;
            4'h1: font = 7'h79;
            4'h2: font = 7'h24;
            4'h3: font = 7'h30;
            4'h4: font = 7'h19;
            4'h5: font = 7'h12;
            4'h6: font = 7'h02;
            4'h7: font = 7'h78;
            4'h8: font = 7'h00;
            4'h9: font = 7'h10;
            4'hA: font = 7'h08;
            4'hB: font = 7'h03;
            4'hC: font = 7'h46;
            4'hD: font = 7'h21;
            4'hE: font = 7'h06;
            default: font = 7'h0E;
        endcase
    endfunction

    assign tick = (pcnt == PCNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r   <= '0;
            b_r   <= '0;
            c_r   <= 1'b0;
            res_r <= '0;
        end else if (load) begin
            a_r   <= in_0;
            b_r   <= in_1;
            c_r   <= cin;
            res_r <= {cout, sum};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= 2'd0;
        end else begin
            pcnt <= tick ? '0 : pcnt + 1'b1;
            if (tick) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Result is at most 31, so a three-threshold compare replaces a divider.
    always_comb begin
        tens     = 2'd0;
        tens_off = 5'd0;
        if (res_r >= 5'd30) begin
            tens     = 2'd3;
            tens_off = 5'd30;
        end else if (res_r >= 5'd20) begin
            tens     = 2'd2;
            tens_off = 5'd20;
        end else if (res_r >= 5'd10) begin
            tens     = 2'd1;
            tens_off = 5'd10;
        end
    end

    always_comb begin
        digit   = 4'd0;
        dp_next = 1'b1;
        an_next = ~(4'b0001 << idx);
        case (idx)
            2'd0: digit = 4'(res_r - tens_off);
            2'd1: digit = {2'b00, tens};
            2'd2: begin
                digit   = b_r;
                dp_next = ~c_r;
            end
            default: digit = a_r;
        endcase
        seg_next = font(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 2'd1 && tens == 2'd0) begin
            seg_next = 7'h7F;
        end
`else
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_add_4_seg_scan.sv
// tb/tb_add_4_seg_scan.sv - randomized self-checking bench for add_4_seg_scan against a frame-position model
module tb_add_4_seg_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load = 1'b0;
    logic [3:0] in_0 = '0;
    logic [3:0] in_1 = '0;
    logic       cin = 1'b0;
    logic [3:0] sum = '0;
    logic       cout = 1'b0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int vectors = 0;
    int miscompares = 0;

    int         edges = 0;
    logic [3:0] m_a = '0;
    logic [3:0] m_b = '0;
    logic       m_c = 1'b0;
    logic [4:0] m_res = '0;

    logic [6:0] font_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    add_4_seg_scan #(.SCAN_DIV(DIV)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .in_0 (in_0),
        .in_1 (in_1),
        .cin  (cin),
        .sum  (sum),
        .cout (cout),
        .an   (an),
        .seg  (seg),
        .dp   (dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected display depends only on how many edges have passed since reset release
    // and on what was captured before the current edge.
    task automatic step();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        int         d;
        int         val;
        @(posedge clk);
        e_an  = 4'b1111;
        e_seg = 7'h7F;
        e_dp  = 1'b1;
        if (!rst_n) begin
            edges = 0;
            m_a = '0; m_b = '0; m_c = 1'b0; m_res = '0;
        end else begin
            d = (edges / DIV) % 4;
            e_an = ~(4'b0001 << d);
            case (d)
                0: begin
                    val   = int'(m_res) % 10;
                    e_seg = font_tbl[val];
                end
                1: begin
                    val   = int'(m_res) / 10;
                    e_seg = font_tbl[val];
`ifdef LEADING_ZERO_BLANK_EN
                    if (val == 0) e_seg = 7'h7F;
`else
`endif
                end
                2: begin
                    e_seg = font_tbl[m_b];
                    e_dp  = ~m_c;
                end
                default: e_seg = font_tbl[m_a];
            endcase
            edges++;
            if (load) begin
                m_a = in_0; m_b = in_1; m_c = cin; m_res = {cout, sum};
            end
        end
        #1;
        check("an", 16'(an), 16'(e_an));
        check("seg", 16'(seg), 16'(e_seg));
        check("dp", 16'(dp), 16'(e_dp));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load_word(input logic [3:0] a, input logic [3:0] b, input logic c,
                             input logic [3:0] s, input logic co);
        in_0 = a; in_1 = b; cin = c; sum = s; cout = co;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic randomize_inputs();
        in_0 = 4'($urandom);
        in_1 = 4'($urandom);
        cin  = 1'($urandom);
        sum  = 4'($urandom);
        cout = 1'($urandom);
    endtask

    initial begin
        run(2);
        rst_n = 1'b1;
        load_word(4'h7, 4'h3, 1'b1, 4'hA, 1'b0);
        run(6);

        // reset mid-frame must blank without waiting for a clock edge
        rst_n = 1'b0;
        #1;
        check("rst_an", 16'(an), 16'hF);
        check("rst_seg", 16'(seg), 16'h7F);
        check("rst_dp", 16'(dp), 16'h1);
        run(2);
        rst_n = 1'b1;
        run(8);

        load_word(4'h9, 4'h8, 1'b1, 4'h2, 1'b1);
        run(16);
        load_word(4'hF, 4'hF, 1'b1, 4'hF, 1'b1);
        run(16);
        load_word(4'h1, 4'h3, 1'b1, 4'h5, 1'b0);
        run(16);

        for (int i = 0; i < 48; i++) begin
            randomize_inputs();
            step();
        end

        for (int i = 0; i < 240; i++) begin
            randomize_inputs();
            load = ($urandom_range(0, 5) == 0);
            step();
        end
        load = 1'b0;

        // reset and load asserted together: reset wins
        randomize_inputs();
        load  = 1'b1;
        rst_n = 1'b0;
        run(2);
        load  = 1'b0;
        rst_n = 1'b1;
        run(16);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
